// File: rtl/array_pkg.sv
// Shared types for the clearable register array: sweep controller state encoding.
package array_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

endpackage : array_pkg

// File: rtl/clearable_array_ctrl.sv
// Clear-sweep controller: walks a pointer across every entry once per clear request.
module clearable_array_ctrl
    import array_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_i,
    output logic                  busy_o,
    output logic                  sweep_en_o,
    output logic [INDEX_BITS-1:0] sweep_ptr_o
);

    localparam logic [INDEX_BITS-1:0] LAST_PTR = {INDEX_BITS{1'b1}};

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // clear is deliberately not looked at in SWEEP, so a sweep never restarts or stretches.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                ptr_d = '0;
                if (clear_i) state_d = SWEEP;
            end
            SWEEP: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == LAST_PTR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q == SWEEP);
        sweep_en_o  = (state_q == SWEEP);
        sweep_ptr_o = ptr_q;
    end

endmodule : clearable_array_ctrl

// File: rtl/clearable_array.sv
// Flip-flop register array with byte-masked writes, combinational read, valid bits,
// a valid-entry counter and a multi-cycle clear sweep.
module clearable_array
    import array_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INDEX_BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [INDEX_BITS-1:0] index,
    input  logic [WIDTH/8-1:0]    wmask,
    input  logic [WIDTH-1:0]      in,
    input  logic                  clear,
    output logic [WIDTH-1:0]      out,
    output logic                  valid_out,
    output logic                  busy,
    output logic [INDEX_BITS:0]   count
);

    localparam int DEPTH  = 2 ** INDEX_BITS;
    localparam int NBYTES = WIDTH / 8;

    // Data is not covered by reset; it powers up as zero and survives rst.
    logic [WIDTH-1:0]      data_q [DEPTH] = '{default: '0};
    logic [DEPTH-1:0]      valid_q;
    logic [INDEX_BITS:0]   count_q, count_d;
    logic                  sweep_en;
    logic [INDEX_BITS-1:0] sweep_ptr;
    logic                  write_en;
    logic [WIDTH-1:0]      merged;

    clearable_array_ctrl #(
        .INDEX_BITS (INDEX_BITS)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .busy_o      (busy),
        .sweep_en_o  (sweep_en),
        .sweep_ptr_o (sweep_ptr)
    );

    assign write_en = write & ~busy;

    generate
        for (genvar gi = 0; gi < NBYTES; gi++) begin : g_merge
            assign merged[8*gi +: 8] = wmask[gi] ? in[8*gi +: 8] : data_q[index][8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (write_en && (index == INDEX_BITS'(i))) begin
                data_q[i] <= merged;
            end else if (sweep_en && (sweep_ptr == INDEX_BITS'(i))) begin
                data_q[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (write_en && (index == INDEX_BITS'(i))) begin
                    valid_q[i] <= 1'b1;
                end else if (sweep_en && (sweep_ptr == INDEX_BITS'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Writes and sweep steps are mutually exclusive, so at most one adjustment per edge.
    always_comb begin
        count_d = count_q;
        if (write_en && !valid_q[index]) begin
            count_d = count_q + 1'b1;
        end else if (sweep_en && valid_q[sweep_ptr]) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign out       = data_q[index];
    assign valid_out = valid_q[index];
    assign count     = count_q;

endmodule : clearable_array

// File: tb/tb_clearable_array.sv
// Directed bench for clearable_array: vector table for writes/reads, hand sequences for sweeps and reset.
module tb_clearable_array;

    localparam int WIDTH      = 32;
    localparam int INDEX_BITS = 3;
    localparam int DEPTH      = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  write;
    logic [INDEX_BITS-1:0] index;
    logic [WIDTH/8-1:0]    wmask;
    logic [WIDTH-1:0]      in;
    logic                  clear;
    logic [WIDTH-1:0]      out;
    logic                  valid_out;
    logic                  busy;
    logic [INDEX_BITS:0]   count;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic                  wr;
        logic [INDEX_BITS-1:0] idx;
        logic [3:0]            msk;
        logic [31:0]           din;
        logic [31:0]           exp_out;
        logic                  exp_valid;
        logic [INDEX_BITS:0]   exp_count;
    } vec_t;

    vec_t vecs [8];

    clearable_array #(
        .WIDTH      (WIDTH),
        .INDEX_BITS (INDEX_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .write     (write),
        .index     (index),
        .wmask     (wmask),
        .in        (in),
        .clear     (clear),
        .out       (out),
        .valid_out (valid_out),
        .busy      (busy),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int idx, input logic [31:0] d);
        write = 1'b1; index = INDEX_BITS'(idx); wmask = 4'hF; in = d;
        step();
        write = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int c = 0; c < max_cycles; c++) begin
            if (!busy) return;
            step();
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int busy_cycles;

        rst = 1'b1; write = 1'b0; index = '0; wmask = '0; in = '0; clear = 1'b0;
        #2;
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_valid", 32'(valid_out), 32'd0);
        check("reset_out",   out, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Table: each vector is applied for one edge, then outputs at the same index are checked.
        vecs[0] = '{1'b1, 3'd5, 4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 4'd1};
        vecs[1] = '{1'b1, 3'd5, 4'h5, 32'h11223344, 32'hDE22BE44, 1'b1, 4'd1};
        vecs[2] = '{1'b1, 3'd0, 4'h1, 32'h000000AA, 32'h000000AA, 1'b1, 4'd2};
        vecs[3] = '{1'b1, 3'd7, 4'h0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 4'd3};
        vecs[4] = '{1'b1, 3'd7, 4'h8, 32'hA5000000, 32'hA5000000, 1'b1, 4'd3};
        vecs[5] = '{1'b1, 3'd0, 4'h2, 32'h0000BB00, 32'h0000BBAA, 1'b1, 4'd3};
        vecs[6] = '{1'b0, 3'd3, 4'hF, 32'h12345678, 32'h00000000, 1'b0, 4'd3};
        vecs[7] = '{1'b0, 3'd5, 4'hF, 32'h00000000, 32'hDE22BE44, 1'b1, 4'd3};

        for (int v = 0; v < 8; v++) begin
            write = vecs[v].wr; index = vecs[v].idx; wmask = vecs[v].msk; in = vecs[v].din;
            step();
            write = 1'b0;
            #1;
            check($sformatf("vec%0d_out", v),   out, vecs[v].exp_out);
            check($sformatf("vec%0d_valid", v), 32'(valid_out), 32'(vecs[v].exp_valid));
            check($sformatf("vec%0d_count", v), 32'(count), 32'(vecs[v].exp_count));
        end

        // Fill, sweep, and confirm writes during the sweep are dropped.
        for (int i = 0; i < DEPTH; i++) do_write(i, 32'h10000000 + i);
        check("fill_count", 32'(count), 32'd8);
        clear = 1'b1;
        step();
        clear = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            check($sformatf("sweep_count_%0d", busy_cycles), 32'(count), 32'(8 - busy_cycles));
            write = 1'b1; index = 3'd3; wmask = 4'hF; in = 32'hFFFFFFFF;
            step();
            write = 1'b0;
            busy_cycles++;
        end
        check("sweep_busy_cycles", 32'(busy_cycles), 32'd8);
        check("sweep_end_count", 32'(count), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            index = INDEX_BITS'(i);
            #1;
            check($sformatf("swept_out_%0d", i),   out, 32'd0);
            check($sformatf("swept_valid_%0d", i), 32'(valid_out), 32'd0);
        end

        // Write and clear on the same edge: write lands, then the sweep removes it.
        write = 1'b1; clear = 1'b1; index = 3'd2; wmask = 4'hF; in = 32'h12345678;
        step();
        write = 1'b0; clear = 1'b0;
        check("wc_busy",  32'(busy), 32'd1);
        check("wc_count", 32'(count), 32'd1);
        check("wc_out",   out, 32'h12345678);
        wait_idle(20);
        check("wc_after_out",   out, 32'd0);
        check("wc_after_valid", 32'(valid_out), 32'd0);
        check("wc_after_count", 32'(count), 32'd0);

        // Reset in the middle of a sweep after three entries have been cleared.
        for (int i = 0; i < DEPTH; i++) do_write(i, (i == 5) ? 32'h55555555 : 32'hC0DE0000 + i);
        clear = 1'b1;
        step();
        clear = 1'b0;
        step(); step(); step();
        check("mid_sweep_count", 32'(count), 32'd5);
        index = 3'd5;
        rst = 1'b1;
        #1;
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_data5", out, 32'h55555555);
        index = 3'd1;
        #1;
        check("rst_data1", out, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Clear held through the sweep: still DEPTH cycles, then a new sweep right after.
        clear = 1'b1;
        step();
        busy_cycles = 0;
        while (busy && busy_cycles < 20) begin
            step();
            busy_cycles++;
        end
        check("held_clear_cycles", 32'(busy_cycles), 32'd8);
        step();
        check("restart_busy", 32'(busy), 32'd1);
        clear = 1'b0;
        wait_idle(20);
        check("restart_done", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_clearable_array
